i2s_receiver: RTL and testbench

I2S slave receiver that recovers stereo audio words from an external serial stream (SCLK, LRCLK, SD) and presents them as parallel frames in the MCLK domain. It is the receiving end of the team's I2S transmitter: same frame format, and the same packing of one 2*WIDTH-bit stereo word (left in the upper half). It sits between the I2S pins and downstream sample consumers (FIFO, DSP, checker ROM compare). All logic runs on MCLK; SCLK and LRCLK are treated as data, never as clocks.

---
 rtl/i2s_receiver_if.sv | 23 ++
 rtl/i2s_receiver.sv | 159 +++++++++++++++
 tb/tb_i2s_receiver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_receiver_if.sv
// I2S receiver pin/frame bundle: serial inputs from the line, parallel frame out.
interface i2s_receiver_if #(
    parameter int WIDTH = 4
);
    logic                 SCLK;
    logic                 LRCLK;
    logic                 SD;
    logic [2*WIDTH-1:0]   Rx;
    logic                 rx_valid;
    logic                 frame_err;

    // Line/consumer side: drives the serial pins, observes the recovered frames.
    modport master (
        output SCLK, LRCLK, SD,
        input  Rx, rx_valid, frame_err
    );

    // Receiver side: samples the serial pins, produces the frames.
    modport slave (
        input  SCLK, LRCLK, SD,
        output Rx, rx_valid, frame_err
    );
endinterface

// File: rtl/i2s_receiver.sv
// Philips-format I2S slave receiver. SCLK/LRCLK/SD are oversampled as data on
// MCLK; a complete {left, right} frame is presented on Rx with a one-cycle
// rx_valid pulse, and any mis-sized channel word gives a one-cycle frame_err.
module i2s_receiver #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           MCLK,
    input  logic           nreset,
    i2s_receiver_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, lr_sync, sd_sync;
    logic                   sclk_prev;
    logic                   lr_prev;
    logic [WIDTH-1:0]       sreg;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       left_hold;
    logic                   left_ok, left_ok_d;
    logic [2*WIDTH-1:0]     rx_q;
    logic                   rx_valid_q, frame_err_q;

    logic                   sclk_s, lr_s, sd_s;
    logic                   sclk_rise, lr_edge, edge_fall, edge_rise;
    logic [WIDTH-1:0]       sreg_shift;
    logic [CW-1:0]          cnt_inc;
    logic                   word_ok;
    logic                   load_left, load_rx, err_d;

    // Bring the three pins into MCLK; LRCLK and SD share depth so they stay aligned with sclk_rise.
    always_ff @(posedge MCLK or negedge nreset) begin
        if (!nreset) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop here sample pre-edge values, so the chain shifts by exactly one stage per clock.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], bus.LRCLK};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], bus.SD};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign lr_s       = lr_sync[SYNC_STAGES-1];
    assign sd_s       = sd_sync[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_prev;
    assign lr_edge    = sclk_rise && (lr_s != lr_prev);
    assign edge_fall  = lr_edge && !lr_s;
    assign edge_rise  = lr_edge && lr_s;
    assign sreg_shift = {sreg[WIDTH-2:0], sd_s};
    assign cnt_inc    = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    assign word_ok    = (cnt_inc == CNT_FULL);

    // Frame state register.
    always_ff @(posedge MCLK or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-edge decisions: word-length check, left latch, frame load, error.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        left_ok_d = left_ok;
        load_left = 1'b0;
        load_rx   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (edge_fall) begin
                    state_d = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (edge_rise) begin
                    state_d = ST_RIGHT;
                    if (word_ok) begin
                        load_left = 1'b1;
                        left_ok_d = 1'b1;
                    end else begin
                        err_d     = 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
            end
            ST_RIGHT: begin
                if (edge_fall) begin
                    state_d   = ST_LEFT;
                    left_ok_d = 1'b0;
                    if (word_ok && left_ok) begin
                        load_rx = 1'b1;
                    end else if (!word_ok) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // Shift, count and word-select tracking, advanced only on a recovered SCLK rise.
    always_ff @(posedge MCLK or negedge nreset) begin
        if (!nreset) begin
            sreg    <= '0;
            cnt     <= '0;
            lr_prev <= 1'b0;
        end else if (sclk_rise) begin
            sreg    <= sreg_shift;
            lr_prev <= lr_s;
            cnt     <= lr_edge ? '0 : cnt_inc;
        end
    end

    // Held left word and output frame; pulses last one MCLK because sclk_rise does.
    always_ff @(posedge MCLK or negedge nreset) begin
        if (!nreset) begin
            left_hold   <= '0;
            left_ok     <= 1'b0;
            rx_q        <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            left_ok     <= left_ok_d;
            rx_valid_q  <= load_rx;
            frame_err_q <= err_d;
            if (load_left) begin
                left_hold <= sreg_shift;
            end
            if (load_rx) begin
                rx_q <= {left_hold, sreg_shift};
            end
        end
    end

    assign bus.Rx        = rx_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives Philips-format frames at SCLK = MCLK/8
// and checks recovered frames, pulse counts and error reporting.
module tb_i2s_receiver;

    localparam int WIDTH = 4;

    logic MCLK;
    logic nreset;
    logic pending;

    int n_checks;
    int n_errors;
    int valid_cnt;
    int err_cnt;

    i2s_receiver_if #(.WIDTH(WIDTH)) bus ();

    i2s_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .MCLK   (MCLK),
        .nreset (nreset),
        .bus    (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // Count output pulses away from the active edge; a stretched pulse counts twice.
    always @(negedge MCLK) begin
        if (bus.rx_valid === 1'b1) valid_cnt++;
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One SCLK period: data changes with SCLK low, receiver samples on the rise.
    task automatic send_bit(input logic lr, input logic sd);
        bus.SCLK  = 1'b0;
        bus.LRCLK = lr;
        bus.SD    = sd;
        repeat (4) @(negedge MCLK);
        bus.SCLK = 1'b1;
        repeat (4) @(negedge MCLK);
    endtask

    // Channel slot: first bit under the new LRCLK is the previous word's LSB.
    task automatic send_word(input logic lr, input logic [7:0] word, input int n);
        send_bit(lr, pending);
        for (int i = n - 1; i >= 1; i--) send_bit(lr, word[i]);
        pending = word[0];
    endtask

    task automatic send_frame(input logic [3:0] l, input logic [3:0] r);
        send_word(1'b0, {4'h0, l}, WIDTH);
        send_word(1'b1, {4'h0, r}, WIDTH);
    endtask

    // Deliver the last right LSB with a 1->0 edge so the frame completes.
    task automatic close_frame();
        send_bit(1'b0, pending);
    endtask

    task automatic do_reset();
        nreset    = 1'b0;
        bus.SCLK  = 1'b0;
        bus.LRCLK = 1'b0;
        bus.SD    = 1'b0;
        pending   = 1'b0;
        repeat (4) @(negedge MCLK);
        nreset = 1'b1;
        repeat (4) @(negedge MCLK);
    endtask

    // Dummy right slot so the receiver sees a 0->1 edge in SYNC, then a 1->0.
    task automatic preamble();
        send_word(1'b1, 8'h00, WIDTH);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no end of stimulus, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int v0;
        int e0;
        n_checks  = 0;
        n_errors  = 0;
        valid_cnt = 0;
        err_cnt   = 0;

        // Reset state
        do_reset();
        check("reset_rx", bus.Rx, 32'h0);
        check("reset_valid", bus.rx_valid, 32'h0);
        check("reset_err", bus.frame_err, 32'h0);

        // Nominal: A/5 then 3/C
        v0 = valid_cnt; e0 = err_cnt;
        preamble();
        send_frame(4'hA, 4'h5);
        send_word(1'b0, 8'h03, WIDTH);
        check("nom_rx_a5", bus.Rx, 32'hA5);
        check("nom_valid1", valid_cnt - v0, 32'd1);
        send_word(1'b1, 8'h0C, WIDTH);
        close_frame();
        check("nom_rx_3c", bus.Rx, 32'h3C);
        check("nom_valid2", valid_cnt - v0, 32'd2);
        check("nom_err", err_cnt - e0, 32'd0);

        // Start mid-stream: reset released partway through a right word
        nreset = 1'b0;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        v0 = valid_cnt; e0 = err_cnt;
        nreset = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        pending = 1'b0;
        send_frame(4'h1, 4'h2);
        close_frame();
        check("mid_rx", bus.Rx, 32'h12);
        check("mid_valid", valid_cnt - v0, 32'd1);
        check("mid_err", err_cnt - e0, 32'd0);

        // Short left word
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        preamble();
        send_word(1'b0, 8'h05, 3);
        send_word(1'b1, 8'h06, WIDTH);
        check("short_err", err_cnt - e0, 32'd1);
        check("short_valid", valid_cnt - v0, 32'd0);
        send_frame(4'hF, 4'h0);
        close_frame();
        check("short_rx_f0", bus.Rx, 32'hF0);
        check("short_valid2", valid_cnt - v0, 32'd1);
        check("short_err2", err_cnt - e0, 32'd1);

        // Long right word
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        preamble();
        send_frame(4'hA, 4'h5);
        send_word(1'b0, 8'h03, WIDTH);
        send_word(1'b1, 8'h1F, 5);
        send_word(1'b0, 8'h0C, WIDTH);
        check("long_rx_hold", bus.Rx, 32'hA5);
        check("long_err", err_cnt - e0, 32'd1);
        check("long_valid", valid_cnt - v0, 32'd1);
        send_word(1'b1, 8'h03, WIDTH);
        close_frame();
        check("long_rx_c3", bus.Rx, 32'hC3);
        check("long_valid2", valid_cnt - v0, 32'd2);
        check("long_err2", err_cnt - e0, 32'd1);

        // Reset mid-frame
        do_reset();
        preamble();
        send_frame(4'hA, 4'h5);
        send_bit(1'b0, pending);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        check("rst_pre_rx", bus.Rx, 32'hA5);
        nreset = 1'b0;
        #1;
        check("rst_rx", bus.Rx, 32'h0);
        check("rst_valid", bus.rx_valid, 32'h0);
        check("rst_err", bus.frame_err, 32'h0);
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        preamble();
        send_frame(4'h9, 4'h6);
        close_frame();
        check("rst_rx_96", bus.Rx, 32'h96);
        check("rst_valid2", valid_cnt - v0, 32'd1);
        check("rst_err2", err_cnt - e0, 32'd0);

        // SCLK stall mid-word: left B = 1011
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        preamble();
        send_bit(1'b0, pending);
        send_bit(1'b0, 1'b1);
        repeat (1000) @(negedge MCLK);
        check("stall_valid", valid_cnt - v0, 32'd0);
        check("stall_err", err_cnt - e0, 32'd0);
        check("stall_rx", bus.Rx, 32'h0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        pending = 1'b1;
        send_word(1'b1, 8'h04, WIDTH);
        close_frame();
        check("stall_rx_b4", bus.Rx, 32'hB4);
        check("stall_valid2", valid_cnt - v0, 32'd1);
        check("stall_err2", err_cnt - e0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
